uart_rx_controller: RTL and testbench

//   UART receive controller: deserializes an 8N1 frame from serial_in into data_out, 16x oversampled.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_rx_os_tick_gen.sv | 51 +++++
 rtl/uart_rx_controller.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_controller.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Baud selection, receiver state encoding and oversample divisor math.
package uart_pkg;

    typedef enum logic [1:0] {
        BAUD_9600,
        BAUD_19200,
        BAUD_57600,
        BAUD_115200
    } baud_set_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int OS_RATE = 16;

    function automatic int baud_rate(input baud_set_t b);
        int r;
        case (b)
            BAUD_9600:   r = 9600;
            BAUD_19200:  r = 19200;
            BAUD_57600:  r = 57600;
            BAUD_115200: r = 115200;
            default:     r = 9600;
        endcase
        return r;
    endfunction

    // Rounded clocks per oversample tick, never below 1.
    function automatic int os_div(input baud_set_t b, input int f_clk);
        int den;
        int q;
        den = baud_rate(b) * OS_RATE;
        q   = (f_clk + den / 2) / den;
        return (q < 1) ? 1 : q;
    endfunction

endpackage

// File: rtl/uart_rx_os_tick_gen.sv
// Oversample tick divider: one-cycle os_tick every os_div(baud) clocks.
// Held at zero while disabled; clear re-phases it to the start edge.
module uart_rx_os_tick_gen
    import uart_pkg::*;
#(
    parameter int F_CLK = 16000000
) (
    input  logic      clk_16mhz,
    input  logic      rst,
    input  logic      enable,
    input  logic      clear,
    input  baud_set_t baud_setting,
    output logic      os_tick
);

    localparam int DIV_MAX = os_div(BAUD_9600, F_CLK);
    localparam int CW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    localparam logic [CW-1:0] TOP_9600   = CW'(os_div(BAUD_9600, F_CLK) - 1);
    localparam logic [CW-1:0] TOP_19200  = CW'(os_div(BAUD_19200, F_CLK) - 1);
    localparam logic [CW-1:0] TOP_57600  = CW'(os_div(BAUD_57600, F_CLK) - 1);
    localparam logic [CW-1:0] TOP_115200 = CW'(os_div(BAUD_115200, F_CLK) - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] top;

    always_comb begin
        top = TOP_9600;
        unique case (baud_setting)
            BAUD_9600:   top = TOP_9600;
            BAUD_19200:  top = TOP_19200;
            BAUD_57600:  top = TOP_57600;
            BAUD_115200: top = TOP_115200;
        endcase
        os_tick = enable && !clear && (cnt_q == top);
        cnt_d   = cnt_q + 1'b1;
        if (clear || !enable || os_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_16mhz) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// 8N1 UART receiver, 16x oversampled, LSB first.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 voting at os_cnt 6/7/8.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int F_CLK      = 16000000
) (
    input  logic                  clk_16mhz,
    input  logic                  rst,
    input  logic                  serial_in,
    input  baud_set_t             baud_setting,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  rx_busy
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [3:0] DECIDE_CNT = 4'd8;
`else
    localparam logic [3:0] DECIDE_CNT = 4'd7;
`endif

    logic                  sync1_q, sync2_q, prev_q, prev_d;
    logic [1:0]            warm_q;
    rx_state_t             state_q, state_d;
    baud_set_t             baud_q, baud_d;
    logic [3:0]            os_cnt_q, os_cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] data_sh_q, data_sh_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  rx_s, start_det, os_tick, decide, bit_val;

    assign rx_s = sync2_q;
    // prev only tracks rx_s once the synchronizer holds real line data,
    // so a line already low at reset exit never looks like a falling edge.
    assign prev_d    = warm_q[1] & rx_s;
    assign start_det = (state_q == IDLE) && !rx_s && prev_q;
    assign decide    = os_tick && (os_cnt_q == DECIDE_CNT);

    uart_rx_os_tick_gen #(
        .F_CLK(F_CLK)
    ) u_tick (
        .clk_16mhz   (clk_16mhz),
        .rst         (rst),
        .enable      (state_q != IDLE),
        .clear       (start_det),
        .baud_setting(baud_q),
        .os_tick     (os_tick)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic v6_q, v6_d, v7_q, v7_d;

    always_comb begin
        v6_d = v6_q;
        v7_d = v7_q;
        if (os_tick && os_cnt_q == 4'd6) v6_d = rx_s;
        if (os_tick && os_cnt_q == 4'd7) v7_d = rx_s;
    end

    always_ff @(posedge clk_16mhz) begin
        if (rst) begin
            v6_q <= 1'b0;
            v7_q <= 1'b0;
        end else begin
            v6_q <= v6_d;
            v7_q <= v7_d;
        end
    end

    assign bit_val = (v6_q & v7_q) | (v6_q & rx_s) | (v7_q & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_sh_d = data_sh_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        if (os_tick) begin
            os_cnt_d = os_cnt_q + 4'd1;
        end
        unique case (state_q)
            IDLE: begin
                os_cnt_d = '0;
                if (start_det) begin
                    state_d   = START;
                    baud_d    = baud_setting;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (decide) begin
                    state_d = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (decide) begin
                    data_sh_d[bit_cnt_q] = bit_val;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                // Leave at mid stop bit so an immediate next start is caught.
                if (decide) begin
                    state_d = IDLE;
                    if (bit_val) begin
                        data_d  = data_sh_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_16mhz) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            warm_q    <= 2'b00;
            prev_q    <= 1'b0;
            state_q   <= IDLE;
            baud_q    <= BAUD_9600;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            data_sh_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync1_q   <= serial_in;
            sync2_q   <= sync1_q;
            warm_q    <= {warm_q[0], 1'b1};
            prev_q    <= prev_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_sh_q <= data_sh_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign data_out  = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = err_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller at 16 MHz.
// Frames are driven bit-serially; pulses are counted by a negedge monitor.
module tb_uart_rx_controller;
    import uart_pkg::*;

    localparam int BC_115200 = 139;
    localparam int BC_9600   = 1667;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int LAT = 2 + 9 * (16 * 9 + 8) + 9;
`else
    localparam int LAT = 2 + 9 * (16 * 9 + 8);
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    baud_set_t  baud_setting;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int n_both   = 0;
    int valid_cyc = 0;
    int fall_cyc  = 0;
    logic [7:0] got[$];

    uart_rx_controller #(
        .DATA_WIDTH(8),
        .F_CLK     (16000000)
    ) dut (
        .clk_16mhz   (clk),
        .rst         (rst),
        .serial_in   (serial_in),
        .baud_setting(baud_setting),
        .data_out    (data_out),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                n_valid++;
                valid_cyc = cyc;
                got.push_back(data_out);
            end
            if (frame_err) n_err++;
            if (rx_valid && frame_err) n_both++;
        end
    end

    // Caller must be just after a posedge; returns just after a posedge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int bc);
        serial_in = 1'b0;
        fall_cyc = cyc;
        repeat (bc) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 serial_in = d[i];
            repeat (bc) @(posedge clk);
        end
        #1 serial_in = stop;
        repeat (bc) @(posedge clk);
        #1 serial_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        serial_in = 1'b1;
        baud_setting = BAUD_115200;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (data_out !== 8'h00) begin
            failures++;
            $display("FAIL rst_data_out got=%h exp=00", data_out);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_rx_valid got=%b exp=0", rx_valid);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_frame_err got=%b exp=0", frame_err);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_rx_busy got=%b exp=0", rx_busy);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_basic();
        int v0, e0, lat;
        v0 = n_valid;
        e0 = n_err;
        @(posedge clk);
        #1;
        fork
            send_frame(8'h55, 1'b1, BC_115200);
            begin
                repeat (300) @(posedge clk);
                #1 baud_setting = BAUD_9600;
            end
        join
        repeat (20) @(posedge clk);
        baud_setting = BAUD_115200;
        checks++;
        if (n_valid - v0 !== 1) begin
            failures++;
            $display("FAIL basic_valid_count got=%0d exp=1", n_valid - v0);
        end
        checks++;
        if (data_out !== 8'h55) begin
            failures++;
            $display("FAIL basic_data got=%h exp=55", data_out);
        end
        checks++;
        if (got.size() == 0 || got[got.size()-1] !== 8'h55) begin
            failures++;
            $display("FAIL basic_data_at_pulse size=%0d exp=55", got.size());
        end
        checks++;
        if (n_err !== e0) begin
            failures++;
            $display("FAIL basic_frame_err got=%0d exp=0", n_err - e0);
        end
        lat = valid_cyc - fall_cyc;
        checks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=%0d+/-1", lat, LAT);
        end
    endtask

    task automatic test_frame_err();
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        @(posedge clk);
        #1;
        send_frame(8'hFF, 1'b0, BC_115200);
        repeat (200) @(posedge clk);
        checks++;
        if (n_err - e0 !== 1) begin
            failures++;
            $display("FAIL ferr_count got=%0d exp=1", n_err - e0);
        end
        checks++;
        if (n_valid !== v0) begin
            failures++;
            $display("FAIL ferr_no_valid got=%0d exp=0", n_valid - v0);
        end
        checks++;
        if (data_out !== 8'h55) begin
            failures++;
            $display("FAIL ferr_data_held got=%h exp=55", data_out);
        end
    endtask

    task automatic test_glitch();
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        @(posedge clk);
        #1 serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rx_busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_start got=%b exp=1", rx_busy);
        end
        repeat (82) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_back_idle got=%b exp=0", rx_busy);
        end
        repeat (200) @(posedge clk);
        checks++;
        if (n_valid !== v0) begin
            failures++;
            $display("FAIL glitch_no_valid got=%0d exp=0", n_valid - v0);
        end
        checks++;
        if (n_err !== e0) begin
            failures++;
            $display("FAIL glitch_no_err got=%0d exp=0", n_err - e0);
        end
    endtask

`ifdef UART_RX_MAJORITY_VOTE_EN
    task automatic test_vote_spike();
        int v0;
        v0 = n_valid;
        @(posedge clk);
        #1 serial_in = 1'b0;
        repeat (646) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (9) @(posedge clk);
        #1 serial_in = 1'b0;
        repeat (641) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (200) @(posedge clk);
        checks++;
        if (n_valid - v0 !== 1) begin
            failures++;
            $display("FAIL vote_valid_count got=%0d exp=1", n_valid - v0);
        end
        checks++;
        if (data_out !== 8'h00) begin
            failures++;
            $display("FAIL vote_spike_data got=%h exp=00", data_out);
        end
    endtask
`endif

    task automatic test_back_to_back();
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        baud_setting = BAUD_9600;
        @(posedge clk);
        #1;
        send_frame(8'hA5, 1'b1, BC_9600);
        checks++;
        if (data_out !== 8'hA5) begin
            failures++;
            $display("FAIL b2b_first_data got=%h exp=a5", data_out);
        end
        send_frame(8'h3C, 1'b1, BC_9600);
        repeat (200) @(posedge clk);
        checks++;
        if (n_valid - v0 !== 2) begin
            failures++;
            $display("FAIL b2b_valid_count got=%0d exp=2", n_valid - v0);
        end
        checks++;
        if (data_out !== 8'h3C) begin
            failures++;
            $display("FAIL b2b_second_data got=%h exp=3c", data_out);
        end
        checks++;
        if (got.size() < 2 || got[got.size()-2] !== 8'hA5) begin
            failures++;
            $display("FAIL b2b_first_at_pulse size=%0d exp=a5", got.size());
        end
        checks++;
        if (n_err !== e0) begin
            failures++;
            $display("FAIL b2b_no_err got=%0d exp=0", n_err - e0);
        end
        baud_setting = BAUD_115200;
    endtask

    task automatic test_rst_mid();
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        @(posedge clk);
        #1 serial_in = 1'b0;
        repeat (BC_115200) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (BC_115200) @(posedge clk);
        #1 serial_in = 1'b0;
        repeat (BC_115200 * 2 + 70) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_busy got=%b exp=0", rx_busy);
        end
        serial_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (1500) @(posedge clk);
        checks++;
        if (n_valid !== v0 || n_err !== e0) begin
            failures++;
            $display("FAIL rstmid_no_pulse valid=%0d err=%0d exp=0/0",
                     n_valid - v0, n_err - e0);
        end
        #1;
        send_frame(8'h42, 1'b1, BC_115200);
        repeat (20) @(posedge clk);
        checks++;
        if (n_valid - v0 !== 1) begin
            failures++;
            $display("FAIL rstmid_valid_count got=%0d exp=1", n_valid - v0);
        end
        checks++;
        if (data_out !== 8'h42) begin
            failures++;
            $display("FAIL rstmid_data got=%h exp=42", data_out);
        end
    endtask

    task automatic test_reset_low();
        int v0, busy_seen;
        v0 = n_valid;
        busy_seen = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        serial_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (180) begin
            @(negedge clk);
            if (rx_busy) busy_seen++;
        end
        checks++;
        if (busy_seen !== 0) begin
            failures++;
            $display("FAIL rstlow_busy_cycles got=%0d exp=0", busy_seen);
        end
        @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (20) @(posedge clk);
        checks++;
        if (n_valid !== v0 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL rstlow_idle valid=%0d busy=%b exp=0/0",
                     n_valid - v0, rx_busy);
        end
        #1;
        send_frame(8'h96, 1'b1, BC_115200);
        repeat (20) @(posedge clk);
        checks++;
        if (n_valid - v0 !== 1) begin
            failures++;
            $display("FAIL rstlow_valid_count got=%0d exp=1", n_valid - v0);
        end
        checks++;
        if (data_out !== 8'h96) begin
            failures++;
            $display("FAIL rstlow_data got=%h exp=96", data_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_err();
        test_glitch();
`ifdef UART_RX_MAJORITY_VOTE_EN
        test_vote_spike();
`endif
        test_back_to_back();
        test_rst_mid();
        test_reset_low();
        checks++;
        if (n_both !== 0) begin
            failures++;
            $display("FAIL valid_and_err_together got=%0d exp=0", n_both);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
